// File: rtl/writeback_commit_unit.sv
// Writeback commit unit: selects the writeback result, drives the register-file
// write port and the forwarding source, retires instructions into the
// cycle/instret counters and records each commit in a small trace FIFO that a
// debug reader drains with a valid/ready handshake.
module writeback_commit_unit #(
    parameter int TRACE_DEPTH = 4,
    parameter int CNT_W       = 64
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_rd_wren_writeback,
    input  logic             i_insn_vld_writeback,
    input  logic [31:0]      i_pc_writeback,
    input  logic [1:0]       i_wb_sel_writeback,
    input  logic [31:0]      i_alu_pc4_data_writeback,
    input  logic [31:0]      i_ld_data_writeback,
    input  logic [4:0]       i_rd_addr_writeback,
    output logic             o_rf_wren,
    output logic [4:0]       o_rf_addr,
    output logic [31:0]      o_rf_data,
    output logic             o_fwd_vld,
    input  logic             i_trace_ready,
    input  logic             i_trace_clr,
    output logic             o_trace_valid,
    output logic [31:0]      o_trace_pc,
    output logic [4:0]       o_trace_rd_addr,
    output logic [31:0]      o_trace_data,
    output logic             o_trace_overflow,
    output logic [CNT_W-1:0] o_cycle,
    output logic [CNT_W-1:0] o_instret
);

    localparam int PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int CNT_FW = PTR_W + 1;

    // Result select; the reserved encodings fall back to the ALU/PC+4 path so a
    // corrupted select never produces an undefined write value.
    function automatic logic [31:0] sel_result(
        input logic [1:0]  sel,
        input logic [31:0] alu_pc4,
        input logic [31:0] ld_data
    );
        logic [31:0] res;
        case (sel)
            2'b00:   res = alu_pc4;
            2'b01:   res = ld_data;
            default: res = alu_pc4;
        endcase
        return res;
    endfunction

    // Trace storage (no reset: stale entries are hidden by the count).
    logic [31:0] pc_mem_q   [TRACE_DEPTH];
    logic [4:0]  rd_mem_q   [TRACE_DEPTH];
    logic [31:0] data_mem_q [TRACE_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_FW-1:0] count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  instret_q, instret_d;

    logic        commit_s;
    logic [31:0] result_s;
    logic        rf_wren_s;
    logic [4:0]  trace_rd_s;
    logic        empty_s;
    logic        full_s;
    logic        pop_s;
    logic        push_acc_s;
    logic        drop_s;

    // Commit qualification, result mux and FIFO handshake decode.
    always_comb begin
        commit_s   = i_insn_vld_writeback & ~i_reset;
        result_s   = sel_result(i_wb_sel_writeback, i_alu_pc4_data_writeback,
                                i_ld_data_writeback);
        rf_wren_s  = commit_s & i_rd_wren_writeback & (i_rd_addr_writeback != 5'd0);
        if (rf_wren_s) begin
            trace_rd_s = i_rd_addr_writeback;
        end else begin
            trace_rd_s = 5'd0;
        end
        empty_s    = (count_q == {CNT_FW{1'b0}});
        full_s     = (count_q == CNT_FW'(TRACE_DEPTH));
        pop_s      = ~empty_s & i_trace_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_acc_s = commit_s & (~full_s | pop_s);
        drop_s     = commit_s & full_s & ~pop_s;
    end

    // Next-state for pointers, occupancy, overflow flag and counters.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        cycle_d    = cycle_q;
        instret_d  = instret_q;
        if (i_reset) begin
            wr_ptr_d   = {PTR_W{1'b0}};
            rd_ptr_d   = {PTR_W{1'b0}};
            count_d    = {CNT_FW{1'b0}};
            overflow_d = 1'b0;
            cycle_d    = {CNT_W{1'b0}};
            instret_d  = {CNT_W{1'b0}};
        end else begin
            if (push_acc_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_acc_s, pop_s})
                2'b10:   count_d = count_q + CNT_FW'(1);
                2'b01:   count_d = count_q - CNT_FW'(1);
                default: count_d = count_q;
            endcase
            // A new drop outranks a clear request in the same cycle.
            if (drop_s) begin
                overflow_d = 1'b1;
            end else if (i_trace_clr) begin
                overflow_d = 1'b0;
            end else begin
                overflow_d = overflow_q;
            end
            cycle_d = cycle_q + CNT_W'(1);
            if (commit_s) begin
                instret_d = instret_q + CNT_W'(1);
            end else begin
                instret_d = instret_q;
            end
        end
    end

    // Control and counter state registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        count_q    <= count_d;
        overflow_q <= overflow_d;
        cycle_q    <= cycle_d;
        instret_q  <= instret_d;
    end

    // Trace entry write at the write pointer on every accepted push.
    always_ff @(posedge i_clk) begin
        if (push_acc_s) begin
            pc_mem_q[wr_ptr_q]   <= i_pc_writeback;
            rd_mem_q[wr_ptr_q]   <= trace_rd_s;
            data_mem_q[wr_ptr_q] <= result_s;
        end
    end

    // Register-file port is combinational so the RF captures it on this edge.
    assign o_rf_wren        = rf_wren_s;
    assign o_rf_addr        = i_rd_addr_writeback;
    assign o_rf_data        = result_s;
    assign o_fwd_vld        = rf_wren_s;

    // Head of FIFO presented straight from storage (first-word fall-through).
    assign o_trace_valid    = ~empty_s;
    assign o_trace_pc       = pc_mem_q[rd_ptr_q];
    assign o_trace_rd_addr  = rd_mem_q[rd_ptr_q];
    assign o_trace_data     = data_mem_q[rd_ptr_q];
    assign o_trace_overflow = overflow_q;
    assign o_cycle          = cycle_q;
    assign o_instret        = instret_q;

endmodule

// File: tb/tb_writeback_commit_unit.sv
// Self-checking bench for writeback_commit_unit: a vector table for the result
// path, hand sequences for FIFO corner cases, and a queue scoreboard for the
// trace FIFO and counters. A second instance with 4-bit counters covers wrap.
module tb_writeback_commit_unit;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
    } trace_t;

    typedef struct {
        logic        rst;
        logic        vld;
        logic        wren;
        logic [31:0] pc;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [4:0]  rd;
        logic        ready;
        logic        clr;
        logic        exp_wren;
        logic [31:0] exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, vld, wren, ready, clr;
    logic [31:0] pc, alu, ld;
    logic [1:0]  sel;
    logic [4:0]  rd;

    logic        o_rf_wren, o_fwd_vld, o_trace_valid, o_trace_overflow;
    logic [4:0]  o_rf_addr, o_trace_rd_addr;
    logic [31:0] o_rf_data, o_trace_pc, o_trace_data;
    logic [63:0] o_cycle, o_instret;

    logic        s_rf_wren, s_fwd_vld, s_trace_valid, s_trace_overflow;
    logic [4:0]  s_rf_addr, s_trace_rd_addr;
    logic [31:0] s_rf_data, s_trace_pc, s_trace_data;
    logic [3:0]  s_cycle, s_instret;

    int n_chk = 0;
    int n_fail = 0;

    trace_t      q[$];
    logic [63:0] cyc_m, ret_m;
    logic        ovf_m;
    vec_t        vecs[8];

    always #5 clk = ~clk;

    writeback_commit_unit #(.TRACE_DEPTH(DEPTH), .CNT_W(64)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_rd_wren_writeback(wren), .i_insn_vld_writeback(vld),
        .i_pc_writeback(pc), .i_wb_sel_writeback(sel),
        .i_alu_pc4_data_writeback(alu), .i_ld_data_writeback(ld),
        .i_rd_addr_writeback(rd),
        .o_rf_wren(o_rf_wren), .o_rf_addr(o_rf_addr), .o_rf_data(o_rf_data),
        .o_fwd_vld(o_fwd_vld),
        .i_trace_ready(ready), .i_trace_clr(clr),
        .o_trace_valid(o_trace_valid), .o_trace_pc(o_trace_pc),
        .o_trace_rd_addr(o_trace_rd_addr), .o_trace_data(o_trace_data),
        .o_trace_overflow(o_trace_overflow),
        .o_cycle(o_cycle), .o_instret(o_instret)
    );

    writeback_commit_unit #(.TRACE_DEPTH(DEPTH), .CNT_W(4)) dut_small (
        .i_clk(clk), .i_reset(rst),
        .i_rd_wren_writeback(wren), .i_insn_vld_writeback(vld),
        .i_pc_writeback(pc), .i_wb_sel_writeback(sel),
        .i_alu_pc4_data_writeback(alu), .i_ld_data_writeback(ld),
        .i_rd_addr_writeback(rd),
        .o_rf_wren(s_rf_wren), .o_rf_addr(s_rf_addr), .o_rf_data(s_rf_data),
        .o_fwd_vld(s_fwd_vld),
        .i_trace_ready(ready), .i_trace_clr(clr),
        .o_trace_valid(s_trace_valid), .o_trace_pc(s_trace_pc),
        .o_trace_rd_addr(s_trace_rd_addr), .o_trace_data(s_trace_data),
        .o_trace_overflow(s_trace_overflow),
        .o_cycle(s_cycle), .o_instret(s_instret)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic r, input logic v, input logic w, input logic [31:0] p,
                          input logic [1:0] s, input logic [31:0] a, input logic [31:0] l,
                          input logic [4:0] d, input logic rdy, input logic c);
        rst = r; vld = v; wren = w; pc = p; sel = s; alu = a; ld = l; rd = d;
        ready = rdy; clr = c;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic tick();
        logic        commit, pop, full, exp_wren;
        logic [31:0] exp_data;
        trace_t      ent;
        @(negedge clk);
        commit   = vld & ~rst;
        exp_wren = commit & wren & (rd != 5'd0);
        exp_data = (sel == 2'b01) ? ld : alu;
        chk("rf_wren", {63'd0, o_rf_wren}, {63'd0, exp_wren});
        chk("fwd_vld", {63'd0, o_fwd_vld}, {63'd0, exp_wren});
        chk("rf_addr", {59'd0, o_rf_addr}, {59'd0, rd});
        chk("rf_data", {32'd0, o_rf_data}, {32'd0, exp_data});
        chk("cycle", o_cycle, cyc_m);
        chk("instret", o_instret, ret_m);
        chk("overflow", {63'd0, o_trace_overflow}, {63'd0, ovf_m});
        chk("trace_valid", {63'd0, o_trace_valid}, {63'd0, (q.size() != 0)});
        chk("s_rf_wren", {63'd0, s_rf_wren}, {63'd0, exp_wren});
        chk("s_cycle", {60'd0, s_cycle}, {60'd0, cyc_m[3:0]});
        chk("s_instret", {60'd0, s_instret}, {60'd0, ret_m[3:0]});
        chk("s_trace_valid", {63'd0, s_trace_valid}, {63'd0, (q.size() != 0)});
        chk("s_overflow", {63'd0, s_trace_overflow}, {63'd0, ovf_m});
        if (q.size() != 0) begin
            chk("trace_pc", {32'd0, o_trace_pc}, {32'd0, q[0].pc});
            chk("trace_rd", {59'd0, o_trace_rd_addr}, {59'd0, q[0].rd});
            chk("trace_data", {32'd0, o_trace_data}, {32'd0, q[0].data});
            chk("s_trace_pc", {32'd0, s_trace_pc}, {32'd0, q[0].pc});
        end
        if (rst) begin
            q.delete();
            cyc_m = 64'd0;
            ret_m = 64'd0;
            ovf_m = 1'b0;
        end else begin
            pop  = (q.size() != 0) && ready;
            full = (q.size() == DEPTH);
            if (commit && full && !pop) ovf_m = 1'b1;
            else if (clr) ovf_m = 1'b0;
            if (pop) void'(q.pop_front());
            if (commit && (!full || pop)) begin
                ent.pc   = pc;
                ent.rd   = exp_wren ? rd : 5'd0;
                ent.data = exp_data;
                q.push_back(ent);
            end
            cyc_m = cyc_m + 64'd1;
            if (commit) ret_m = ret_m + 64'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 5'd0, rdy, 1'b0);
            tick();
        end
    endtask

    task automatic do_reset();
        set_in(1'b1, 1'b1, 1'b1, 32'hBAD0, 2'b00, 32'h1, 32'h2, 5'd7, 1'b1, 1'b0);
        tick();
    endtask

    task automatic commit_one(input logic [31:0] p, input logic [4:0] d,
                              input logic [31:0] a, input logic rdy, input logic c);
        set_in(1'b0, 1'b1, 1'b1, p, 2'b00, a, 32'hFFFF_0000, d, rdy, c);
        tick();
    endtask

    initial begin
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        cyc_m = 64'd0;
        ret_m = 64'd0;
        ovf_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset then 10 idle cycles.
        idle(1'b0, 10);
        chk("idle_cycle10", o_cycle, 64'd10);
        chk("idle_instret0", o_instret, 64'd0);
        chk("idle_valid0", {63'd0, o_trace_valid}, 64'd0);

        // rst vld wren pc sel alu ld rd ready clr exp_wren exp_data
        vecs[0] = '{1'b0, 1'b1, 1'b1, 32'h100, 2'b01, 32'h1234, 32'hDEADBEEF, 5'd5, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h0,   2'b00, 32'h0,    32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h104, 2'b00, 32'h55,   32'h99,       5'd0, 1'b1, 1'b0, 1'b0, 32'h55};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h108, 2'b10, 32'hA5A5, 32'hFFFF,     5'd31, 1'b0, 1'b0, 1'b1, 32'hA5A5};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h10C, 2'b11, 32'h7,    32'h9,        5'd3, 1'b1, 1'b0, 1'b0, 32'h7};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h110, 2'b01, 32'h1,    32'h42,       5'd4, 1'b1, 1'b0, 1'b0, 32'h42};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h114, 2'b01, 32'h2,    32'h600D,     5'd9, 1'b1, 1'b0, 1'b1, 32'h600D};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h118, 2'b00, 32'h3,    32'h4,        5'd6, 1'b1, 1'b0, 1'b0, 32'h3};
        for (int i = 0; i < 7; i++) begin
            set_in(vecs[i].rst, vecs[i].vld, vecs[i].wren, vecs[i].pc, vecs[i].sel,
                   vecs[i].alu, vecs[i].ld, vecs[i].rd, vecs[i].ready, vecs[i].clr);
            #3;
            chk($sformatf("vec%0d_wren", i), {63'd0, o_rf_wren}, {63'd0, vecs[i].exp_wren});
            chk($sformatf("vec%0d_data", i), {32'd0, o_rf_data}, {32'd0, vecs[i].exp_data});
            tick();
            if (i == 0) begin
                chk("first_head_pc", {32'd0, o_trace_pc}, 64'h100);
                chk("first_head_rd", {59'd0, o_trace_rd_addr}, 64'd5);
                chk("first_head_data", {32'd0, o_trace_data}, 64'hDEADBEEF);
                chk("first_instret", o_instret, 64'd1);
            end
        end
        idle(1'b1, 6);
        set_in(vecs[7].rst, vecs[7].vld, vecs[7].wren, vecs[7].pc, vecs[7].sel,
               vecs[7].alu, vecs[7].ld, vecs[7].rd, vecs[7].ready, vecs[7].clr);
        #3;
        chk("vec7_wren_in_reset", {63'd0, o_rf_wren}, {63'd0, vecs[7].exp_wren});
        tick();
        chk("vec7_instret_zero", o_instret, 64'd0);

        // Overflow: 5 commits into 4 entries with no reader, clear races a drop.
        for (int i = 0; i < 5; i++) commit_one(32'h200 + 32'(i * 4), 5'(i + 1), 32'h1000 + 32'(i), 1'b0, 1'b0);
        chk("ovf_set", {63'd0, o_trace_overflow}, 64'd1);
        chk("ovf_head_kept", {32'd0, o_trace_pc}, 64'h200);
        commit_one(32'h300, 5'd10, 32'h3000, 1'b0, 1'b1);
        chk("ovf_set_wins", {63'd0, o_trace_overflow}, 64'd1);
        idle(1'b0, 2);
        chk("ovf_head_stable", {32'd0, o_trace_pc}, 64'h200);
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        tick();
        chk("ovf_cleared", {63'd0, o_trace_overflow}, 64'd0);
        idle(1'b1, 5);
        chk("drained_empty", {63'd0, o_trace_valid}, 64'd0);

        // Full FIFO with push and pop together.
        for (int i = 0; i < 4; i++) commit_one(32'h400 + 32'(i * 4), 5'd2, 32'h40 + 32'(i), 1'b0, 1'b0);
        commit_one(32'h410, 5'd3, 32'h44, 1'b1, 1'b0);
        chk("full_pp_no_ovf", {63'd0, o_trace_overflow}, 64'd0);
        chk("full_pp_head2", {32'd0, o_trace_pc}, 64'h404);
        idle(1'b1, 4);
        chk("full_pp_count4", {63'd0, o_trace_valid}, 64'd0);

        // Counter wrap on the 4-bit instance after 16 commits.
        do_reset();
        for (int i = 0; i < 16; i++) commit_one(32'h500 + 32'(i * 4), 5'd1, 32'(i), 1'b1, 1'b0);
        chk("wrap_small_instret", {60'd0, s_instret}, 64'd0);
        chk("wrap_big_instret", o_instret, 64'd16);

        // Reset with 3 entries pending and the reader ready.
        idle(1'b1, 2);
        for (int i = 0; i < 3; i++) commit_one(32'h600 + 32'(i * 4), 5'd8, 32'(i), 1'b0, 1'b0);
        set_in(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
        tick();
        chk("rst_valid0", {63'd0, o_trace_valid}, 64'd0);
        chk("rst_cycle0", o_cycle, 64'd0);
        chk("rst_instret0", o_instret, 64'd0);
        idle(1'b1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_commit_unit.md
Name: writeback_commit_unit

Overview:
Consumer end of the memory/writeback pipeline interface. Takes the writeback-stage control and data bundle and selects the result. Drives the register-file write port and the writeback forwarding source. Retires instructions into 64-bit cycle/instret counters and into a commit-trace FIFO, which a debug/IO reader drains with a valid/ready handshake.

Parameters:
TRACE_DEPTH, 4, number of trace FIFO entries; power of two, minimum 2
CNT_W, 64, width of the cycle and instret counters

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_reset  input  1  synchronous, active-high reset
i_rd_wren_writeback  input  1  instruction writes rd
i_insn_vld_writeback  input  1  slot holds a real (non-bubble) instruction
i_pc_writeback  input  32  PC of writeback instruction
i_wb_sel_writeback  input  2  result select: 00 alu/pc4, 01 load data, 10/11 reserved
i_alu_pc4_data_writeback  input  32  ALU result or PC+4
i_ld_data_writeback  input  32  load data from LSU
i_rd_addr_writeback  input  5  destination register
o_rf_wren  output  1  register-file write enable
o_rf_addr  output  5  register-file write address
o_rf_data  output  32  register-file write data
o_fwd_vld  output  1  forwarding source valid (same as o_rf_wren)
i_trace_ready  input  1  reader accepts head trace entry
i_trace_clr  input  1  clears the sticky overflow flag
o_trace_valid  output  1  trace FIFO non-empty
o_trace_pc  output  32  head entry PC
o_trace_rd_addr  output  5  head entry rd (0 if no write)
o_trace_data  output  32  head entry result data
o_trace_overflow  output  1  sticky: a commit was dropped
o_cycle  output  CNT_W  cycles since reset
o_instret  output  CNT_W  retired instructions since reset

Behaviour:
- Commit condition: commit = i_insn_vld_writeback & ~i_reset.
- Result mux (combinational): wb_sel 00 -> alu_pc4; 01 -> ld_data; 10/11 -> alu_pc4.
- o_rf_wren = commit & i_rd_wren_writeback & (i_rd_addr_writeback != 0). The write to x0 is suppressed.
- o_rf_addr and o_rf_data are driven unconditionally from the inputs and the mux. The register file captures them on the same edge, so the result is visible in the RF at +1 cycle.
- o_fwd_vld equals o_rf_wren. Zero added latency for writeback-to-execute forwarding.
- o_rf_wren = 0 while i_reset is high, regardless of the inputs.
- o_cycle: +1 every cycle when not in reset. Wraps modulo 2^CNT_W.
- o_instret: +1 on each commit, including non-writing instructions such as stores and branches. Bubbles (insn_vld=0) are not counted. Wraps modulo 2^CNT_W.
- Trace FIFO: circular buffer with read/write pointers plus a count of width log2(TRACE_DEPTH)+1.
  - push = commit.
  - pop = o_trace_valid & i_trace_ready.
  - Entry = {pc, rf_wren ? rd_addr : 0, mux result}.
- Head outputs are driven from the storage at the read pointer (registered, FWFT).
  - A pushed entry appears on o_trace_valid on the cycle after the push.
  - When the FIFO is not empty, the head outputs hold stable while o_trace_valid=1 and i_trace_ready=0.
- FIFO boundary cases:
  - Full and push without pop: the entry is dropped, o_trace_overflow is set, and the FIFO contents are unchanged.
  - Full with simultaneous push and pop: both are accepted, count stays the same, no overflow.
  - Empty with push: no bypass. o_trace_valid rises the next cycle; i_trace_ready is ignored while empty.
  - Pointer wrap at TRACE_DEPTH is modulo the depth.
- Overflow flag clear/set:
  - i_trace_clr clears o_trace_overflow on the next edge.
  - If clear and a new drop happen in the same cycle, set wins: the flag stays 1.
- Reset: on any edge with i_reset=1 the following are forced:
  - o_cycle=0, o_instret=0.
  - FIFO pointers and count = 0, so o_trace_valid=0 on the next cycle.
  - o_trace_overflow=0.
  - Stale FIFO data is not cleared but is unobservable.
  - A commit presented in the same cycle as reset is discarded.
- Reset mid-drain: pending entries are lost, with no partial pop.

Test Plan:
- Reset then 10 idle cycles (insn_vld=0) -> o_cycle=10, o_instret=0, o_trace_valid=0, o_rf_wren=0.
- Commit pc=0x100, wren=1, rd=5, wb_sel=01, ld=0xDEADBEEF, alu=0x1234 -> same cycle o_rf_wren=1, addr=5, data=0xDEADBEEF. Next cycle trace head = {0x100, 5, 0xDEADBEEF}, o_instret=1.
- Commit with rd=0, wren=1, wb_sel=00, alu=0x55 -> o_rf_wren=0, o_instret increments, trace rd_addr=0, data=0x55.
- Ready=0 and 5 commits with TRACE_DEPTH=4 -> 4 entries held, 5th dropped, o_trace_overflow=1. Then ready=1 drains the 4 in order. Asserting i_trace_clr together with a 6th dropped commit keeps the flag at 1.
- FIFO full with push and pop in the same cycle -> count stays 4, no overflow, head advances to the 2nd entry.
- Preload o_instret near wrap (force 2^64-1), one commit -> wraps to 0. Assert reset with 3 entries queued -> o_trace_valid=0, counters 0 on the next cycle.
